di_term_router: RTL

Parametrised data-interface (di) terminal router for the FX3-attached FPGA top level. It decodes `di_term_addr` against `NUM_TERMS` terminal addresses and steers per-terminal ready, read-data and status back to the host. It adds a ready-timeout watchdog so a hung terminal cannot stall the host, and a software-reset stretcher. The block replaces the hand-written single-terminal mux in each project top; every terminal instance plugs into one port slice.

---
 rtl/di_pkg.sv | 38 +++
 rtl/di_reset_stretch.sv | 48 ++++
 rtl/di_term_router.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/di_pkg.sv
// Purpose : shared constants, watchdog state type and host-side output bundle for the di router.
// Latency : n/a (declarations only).
// Backpr. : n/a; host backpressure is carried by the ready bits in di_host_t.
// Terminal address values themselves live in terminals_defs.v and feed TERM_ADDRS at the project top.
package di_pkg;

    localparam int DI_ADDR_W = 16;
    localparam int DI_DATA_W = 32;
    localparam int DI_STAT_W = 16;

    // Values returned to the host when no terminal owns the address.
    localparam logic [DI_DATA_W-1:0] DI_UNMAPPED_DATA   = 32'hAAAAAAAA;
    localparam logic [DI_STAT_W-1:0] DI_STATUS_UNMAPPED = 16'hFFFF;

    // Values returned to the host while the watchdog holds a hung transfer.
    localparam logic [DI_DATA_W-1:0] DI_TIMEOUT_DATA    = 32'hDEADBEEF;
    localparam logic [DI_STAT_W-1:0] DI_STATUS_TIMEOUT  = 16'hFFFE;

    typedef enum logic [1:0] {
        WD_IDLE    = 2'd0,
        WD_ACTIVE  = 2'd1,
        WD_TIMEOUT = 2'd2
    } di_wd_state_e;

    // Everything the router drives back to the host, registered as one unit.
    typedef struct packed {
        logic                 read_rdy;
        logic                 write_rdy;
        logic [DI_DATA_W-1:0] datao;
        logic [DI_STAT_W-1:0] status;
    } di_host_t;

    // 16-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] di_sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/di_reset_stretch.sv
// Purpose : stretches a software reset request into a RESET_HOLD-clock active-low reset pulse.
// Latency : request -> o_core_resetb low at the next edge; high again RESET_HOLD edges after the request edge.
// Backpr. : requests are ignored while i_write_mode is high so an in-flight host write is never cut.
// Ports   : i_clk, i_rst (async, active-high), i_sw_reset, i_write_mode -> o_core_resetb.
// After i_rst falls the counter starts from 0, so o_core_resetb also rises RESET_HOLD edges later.
module di_reset_stretch #(
    parameter int RESET_HOLD = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sw_reset,
    input  logic i_write_mode,
    output logic o_core_resetb
);

    localparam logic [7:0] HOLD = 8'(RESET_HOLD);

    logic [7:0] r_rst_cnt;
    logic       r_core_resetb;
    logic [7:0] w_cnt_nxt;
    logic       w_restart;

    assign w_restart = i_sw_reset & ~i_write_mode;

    // Counter parks at HOLD; a fresh request mid-count starts it over.
    always_comb begin
        w_cnt_nxt = r_rst_cnt;
        if (w_restart) begin
            w_cnt_nxt = '0;
        end else if (r_rst_cnt != HOLD) begin
            w_cnt_nxt = r_rst_cnt + 8'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rst_cnt     <= '0;
            r_core_resetb <= 1'b0;
        end else begin
            r_rst_cnt     <= w_cnt_nxt;
            // Registered from the next count so the output is glitch-free.
            r_core_resetb <= (w_cnt_nxt == HOLD);
        end
    end

    assign o_core_resetb = r_core_resetb;

endmodule

// File: rtl/di_term_router.sv
// Purpose : decodes the host terminal address, steers the selected terminal's ready/data/status to the host,
//           and guards the host against hung terminals with a ready-timeout watchdog.
// Latency : address -> t_sel 1 edge; terminal ready/data/status -> host 1 edge (address -> host 2 edges).
// Backpr. : host ready follows the selected terminal; unmapped or timed-out accesses report ready=1.
// Ports   : ifclk/reset (async, active-high); di_* host qualifiers in, di_* host results out;
//           t_* per-terminal slices in, t_sel one-hot out; core_resetb stretched reset; timeout_count.
module di_term_router
    import di_pkg::*;
#(
    parameter int                        NUM_TERMS      = 4,
    parameter logic [16*NUM_TERMS-1:0]   TERM_ADDRS     = {16'h0003, 16'h0002, 16'h0001, 16'h0000},
    parameter int                        TIMEOUT_CYCLES = 1024,
    parameter int                        RESET_HOLD     = 4
) (
    input  logic                        ifclk,
    input  logic                        reset,
    input  logic [DI_ADDR_W-1:0]        di_term_addr,
    input  logic                        di_read_mode,
    input  logic                        di_read_req,
    input  logic                        di_write_mode,
    input  logic                        di_write,
    input  logic                        sw_reset,
    input  logic [NUM_TERMS-1:0]        t_read_rdy,
    input  logic [NUM_TERMS-1:0]        t_write_rdy,
    input  logic [32*NUM_TERMS-1:0]     t_reg_datao,
    input  logic [16*NUM_TERMS-1:0]     t_transfer_status,
    output logic [NUM_TERMS-1:0]        t_sel,
    output logic                        di_read_rdy,
    output logic                        di_write_rdy,
    output logic [DI_DATA_W-1:0]        di_reg_datao,
    output logic [DI_STAT_W-1:0]        di_transfer_status,
    output logic                        core_resetb,
    output logic [15:0]                 timeout_count
);

    localparam logic [NUM_TERMS-1:0] ONE     = NUM_TERMS'(1);
    localparam logic [15:0]          TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [NUM_TERMS-1:0] w_match;
    logic [NUM_TERMS-1:0] w_sel_nxt;
    logic [NUM_TERMS-1:0] r_t_sel;

    always_comb begin
        w_match = '0;
        for (int i = 0; i < NUM_TERMS; i++) begin
            w_match[i] = (di_term_addr == TERM_ADDRS[16*i +: 16]);
        end
        // x & -x isolates the lowest set bit: duplicate addresses resolve to the lowest index.
        w_sel_nxt = w_match & (~w_match + ONE);
    end

    // ------------------------------------------------------------------
    // Selected terminal slice (from the registered select)
    // ------------------------------------------------------------------
    logic                 w_hit;
    logic                 w_sel_rd_rdy;
    logic                 w_sel_wr_rdy;
    logic [DI_DATA_W-1:0] w_sel_data;
    logic [DI_STAT_W-1:0] w_sel_stat;

    assign w_hit        = |r_t_sel;
    assign w_sel_rd_rdy = |(r_t_sel & t_read_rdy);
    assign w_sel_wr_rdy = |(r_t_sel & t_write_rdy);

    always_comb begin
        w_sel_data = '0;
        w_sel_stat = '0;
        for (int i = 0; i < NUM_TERMS; i++) begin
            if (r_t_sel[i]) begin
                w_sel_data = t_reg_datao[32*i +: 32];
                w_sel_stat = t_transfer_status[16*i +: 16];
            end
        end
    end

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    logic w_any_mode;
    logic w_rd_pend;
    logic w_wr_pend;
    logic w_pending;
    logic w_unready;

    assign w_any_mode = di_read_mode | di_write_mode;
    assign w_rd_pend  = di_read_mode & di_read_req;
    assign w_wr_pend  = di_write_mode & di_write;
    assign w_pending  = w_rd_pend | w_wr_pend;
    // An unmapped address counts as ready, so it can never run the counter.
    assign w_unready  = w_hit & ((w_rd_pend & ~w_sel_rd_rdy) | (w_wr_pend & ~w_sel_wr_rdy));

    di_wd_state_e r_state;
    di_wd_state_e w_state_nxt;
    logic [15:0]  r_wait_cnt;
    logic [15:0]  w_wait_cnt_nxt;
    logic [15:0]  r_timeout_count;
    logic [15:0]  w_timeout_count_nxt;

    always_comb begin
        w_state_nxt         = r_state;
        w_wait_cnt_nxt      = r_wait_cnt;
        w_timeout_count_nxt = r_timeout_count;
        case (r_state)
            WD_IDLE: begin
                w_wait_cnt_nxt = '0;
                if (w_any_mode) begin
                    w_state_nxt = WD_ACTIVE;
                end
            end
            WD_ACTIVE: begin
                if (!w_any_mode) begin
                    w_state_nxt    = WD_IDLE;
                    w_wait_cnt_nxt = '0;
                end else if (w_pending && (r_wait_cnt == TO_LAST)) begin
                    // The last counted cycle with the request still up: give up on the terminal.
                    w_state_nxt         = WD_TIMEOUT;
                    w_wait_cnt_nxt      = '0;
                    w_timeout_count_nxt = di_sat_inc16(r_timeout_count);
                end else if (w_unready) begin
                    w_wait_cnt_nxt = r_wait_cnt + 16'd1;
                end else begin
                    w_wait_cnt_nxt = '0;
                end
            end
            WD_TIMEOUT: begin
                // Held until the host drops both modes, so the error is seen for the whole transfer.
                w_wait_cnt_nxt = '0;
                if (!w_any_mode) begin
                    w_state_nxt = WD_IDLE;
                end
            end
            default: begin
                w_state_nxt    = WD_IDLE;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Host output mux (registered)
    // ------------------------------------------------------------------
    di_host_t r_host;
    di_host_t w_host_nxt;

    always_comb begin
        w_host_nxt = '{read_rdy: 1'b1, write_rdy: 1'b1,
                       datao: DI_UNMAPPED_DATA, status: DI_STATUS_UNMAPPED};
        if (r_state == WD_TIMEOUT) begin
            w_host_nxt = '{read_rdy: 1'b1, write_rdy: 1'b1,
                           datao: DI_TIMEOUT_DATA, status: DI_STATUS_TIMEOUT};
        end else if (w_hit) begin
            w_host_nxt = '{read_rdy: w_sel_rd_rdy, write_rdy: w_sel_wr_rdy,
                           datao: w_sel_data, status: w_sel_stat};
        end
    end

    always_ff @(posedge ifclk or posedge reset) begin
        if (reset) begin
            r_t_sel         <= '0;
            r_state         <= WD_IDLE;
            r_wait_cnt      <= '0;
            r_timeout_count <= '0;
            r_host          <= '0;
        end else begin
            r_t_sel         <= w_sel_nxt;
            r_state         <= w_state_nxt;
            r_wait_cnt      <= w_wait_cnt_nxt;
            r_timeout_count <= w_timeout_count_nxt;
            r_host          <= w_host_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Software reset stretcher
    // ------------------------------------------------------------------
    logic w_core_resetb;

    di_reset_stretch #(
        .RESET_HOLD (RESET_HOLD)
    ) u_reset_stretch (
        .i_clk         (ifclk),
        .i_rst         (reset),
        .i_sw_reset    (sw_reset),
        .i_write_mode  (di_write_mode),
        .o_core_resetb (w_core_resetb)
    );

    assign t_sel              = r_t_sel;
    assign di_read_rdy        = r_host.read_rdy;
    assign di_write_rdy       = r_host.write_rdy;
    assign di_reg_datao       = r_host.datao;
    assign di_transfer_status = r_host.status;
    assign core_resetb        = w_core_resetb;
    assign timeout_count      = r_timeout_count;

endmodule
